// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter: source encodings and payload sizing.
package cdb_arbiter_pkg;

    localparam int ROB_POS_WID = 4;

    localparam logic [1:0] CDB_SRC_ALU = 2'd0;
    localparam logic [1:0] CDB_SRC_LSB = 2'd1;
    localparam logic [1:0] CDB_SRC_MUL = 2'd2;

    // Payload layout, MSB first: {rob_pos, val, jump, pc}
    function automatic int payload_w(input int rob_w);
        return rob_w + 32 + 1 + 32;
    endfunction

    localparam int CDB_PAYLOAD_W = payload_w(ROB_POS_WID);

    function automatic logic [1:0] rr_next(input logic [1:0] src);
        return (src == CDB_SRC_MUL) ? CDB_SRC_ALU : src + 2'd1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Small skid FIFO holding completed results until the CDB arbiter grants them.
module cdb_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             enq,
    input  logic             deq,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq) tail <= tail + 1'b1;
                if (deq) head <= head + 1'b1;
                unique case ({enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (rdy && !rst && !flush && enq) mem[tail] <= din;
    end

    assign dout  = mem[head];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single result broadcast bus between ALU, LSB and MUL.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_POS_W  = ROB_POS_WID,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ROB_POS_W-1:0] alu_rob_pos,
    input  logic [31:0]          alu_val,
    input  logic                 alu_jump,
    input  logic [31:0]          alu_pc,
    input  logic                 lsb_valid,
    output logic                 lsb_ready,
    input  logic [ROB_POS_W-1:0] lsb_rob_pos,
    input  logic [31:0]          lsb_val,
    input  logic                 mul_valid,
    output logic                 mul_ready,
    input  logic [ROB_POS_W-1:0] mul_rob_pos,
    input  logic [31:0]          mul_val,
    output logic                 cdb_valid,
    output logic [1:0]           cdb_src,
    output logic [ROB_POS_W-1:0] cdb_rob_pos,
    output logic [31:0]          cdb_val,
    output logic                 cdb_jump,
    output logic [31:0]          cdb_pc
);
    localparam int PW = payload_w(ROB_POS_W);

    logic [PW-1:0] din  [3];
    logic [PW-1:0] head [3];
    logic [2:0]    empty;
    logic [2:0]    full;
    logic [2:0]    enq;
    logic [2:0]    deq;

    logic [1:0]    last_grant;
    logic [1:0]    winner;
    logic [1:0]    idx;
    logic          grant;
    logic [PW-1:0] head_sel;

    assign din[0] = {alu_rob_pos, alu_val, alu_jump, alu_pc};
    assign din[1] = {lsb_rob_pos, lsb_val, 1'b0, 32'd0};
    assign din[2] = {mul_rob_pos, mul_val, 1'b0, 32'd0};

    assign alu_ready = !full[0];
    assign lsb_ready = !full[1];
    assign mul_ready = !full[2];

    assign enq[0] = alu_valid && alu_ready && !rollback;
    assign enq[1] = lsb_valid && lsb_ready && !rollback;
    assign enq[2] = mul_valid && mul_ready && !rollback;

    for (genvar i = 0; i < 3; i++) begin : g_fifo
        cdb_fifo #(
            .WIDTH (PW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .rdy   (rdy),
            .flush (rollback),
            .enq   (enq[i]),
            .deq   (deq[i]),
            .din   (din[i]),
            .dout  (head[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
    end

    // Scan the FIFO heads starting one past the previous winner.
    always_comb begin
        grant  = 1'b0;
        winner = CDB_SRC_ALU;
        idx    = rr_next(last_grant);
        for (int k = 0; k < 3; k++) begin
            if (!grant && !empty[idx]) begin
                grant  = 1'b1;
                winner = idx;
            end
            idx = rr_next(idx);
        end
    end

    always_comb begin
        head_sel = head[0];
        if (winner == CDB_SRC_LSB) head_sel = head[1];
        if (winner == CDB_SRC_MUL) head_sel = head[2];
    end

    assign deq = grant ? (3'b001 << winner) : 3'b000;

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid   <= 1'b0;
            cdb_src     <= CDB_SRC_ALU;
            cdb_rob_pos <= '0;
            cdb_val     <= '0;
            cdb_jump    <= 1'b0;
            cdb_pc      <= '0;
            last_grant  <= CDB_SRC_MUL;
        end else if (rdy) begin
            if (rollback) begin
                cdb_valid  <= 1'b0;
                last_grant <= CDB_SRC_MUL;
            end else if (grant) begin
                cdb_valid <= 1'b1;
                cdb_src   <= winner;
                {cdb_rob_pos, cdb_val, cdb_jump, cdb_pc} <= head_sel;
                last_grant <= winner;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench: a queue-based model predicts each broadcast; a negedge monitor checks the bus.
module tb_cdb_arbiter;
    localparam int RW    = 4;
    localparam int DEPTH = 2;

    typedef struct {
        logic [1:0]    src;
        logic [RW-1:0] pos;
        logic [31:0]   val;
        logic          jump;
        logic [31:0]   pc;
    } res_t;

    logic clk = 0;
    logic rst = 1, rdy = 1, rollback = 0;
    logic alu_valid = 0, lsb_valid = 0, mul_valid = 0;
    logic alu_ready, lsb_ready, mul_ready;
    logic [RW-1:0] alu_rob_pos = 0, lsb_rob_pos = 0, mul_rob_pos = 0;
    logic [31:0] alu_val = 0, lsb_val = 0, mul_val = 0, alu_pc = 0;
    logic alu_jump = 0;
    logic cdb_valid, cdb_jump;
    logic [1:0] cdb_src;
    logic [RW-1:0] cdb_rob_pos;
    logic [31:0] cdb_val, cdb_pc;

    cdb_arbiter #(.ROB_POS_W(RW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rob_pos(alu_rob_pos),
        .alu_val(alu_val), .alu_jump(alu_jump), .alu_pc(alu_pc),
        .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_rob_pos(lsb_rob_pos), .lsb_val(lsb_val),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_rob_pos(mul_rob_pos), .mul_val(mul_val),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_pos(cdb_rob_pos),
        .cdb_val(cdb_val), .cdb_jump(cdb_jump), .cdb_pc(cdb_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-source queues, round-robin starting after the last winner.
    res_t q_alu[$], q_lsb[$], q_mul[$];
    res_t exp_q[$];
    res_t held;
    int   last = 2;
    int   m_state = 0;   // 0 idle, 1 new broadcast, 2 frozen hold, 3 just reset
    bit   started = 0;
    bit   acc_alu, acc_lsb, acc_mul;
    bit   seen_lsb_full = 0;

    function automatic int qsize(input int s);
        return (s == 0) ? q_alu.size() : (s == 1) ? q_lsb.size() : q_mul.size();
    endfunction

    always @(posedge clk) begin
        res_t r;
        int   win;
        bit   a_ok, l_ok, m_ok;
        acc_alu = 0; acc_lsb = 0; acc_mul = 0;
        if (rst) begin
            q_alu.delete(); q_lsb.delete(); q_mul.delete();
            last = 2; m_state = 3; started = 1;
        end else if (!rdy) begin
            if (m_state == 1) m_state = 2;
        end else if (rollback) begin
            q_alu.delete(); q_lsb.delete(); q_mul.delete();
            last = 2; m_state = 0;
        end else begin
            a_ok = alu_valid && q_alu.size() < DEPTH;
            l_ok = lsb_valid && q_lsb.size() < DEPTH;
            m_ok = mul_valid && q_mul.size() < DEPTH;
            win = -1;
            for (int k = 1; k <= 3; k++)
                if (win < 0 && qsize((last + k) % 3) > 0) win = (last + k) % 3;
            if (win >= 0) begin
                if (win == 0) r = q_alu.pop_front();
                else if (win == 1) r = q_lsb.pop_front();
                else r = q_mul.pop_front();
                exp_q.push_back(r);
                last = win; m_state = 1;
            end else begin
                m_state = 0;
            end
            if (a_ok) begin
                r.src = 0; r.pos = alu_rob_pos; r.val = alu_val; r.jump = alu_jump; r.pc = alu_pc;
                q_alu.push_back(r); acc_alu = 1;
            end
            if (l_ok) begin
                r.src = 1; r.pos = lsb_rob_pos; r.val = lsb_val; r.jump = 0; r.pc = 0;
                q_lsb.push_back(r); acc_lsb = 1;
            end
            if (m_ok) begin
                r.src = 2; r.pos = mul_rob_pos; r.val = mul_val; r.jump = 0; r.pc = 0;
                q_mul.push_back(r); acc_mul = 1;
            end
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (started) begin
            chk("alu_ready", 128'(alu_ready), 128'(q_alu.size() < DEPTH));
            chk("lsb_ready", 128'(lsb_ready), 128'(q_lsb.size() < DEPTH));
            chk("mul_ready", 128'(mul_ready), 128'(q_mul.size() < DEPTH));
            if (!lsb_ready) seen_lsb_full = 1;
            case (m_state)
                3: chk("reset_outputs", {cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc}, 128'd0);
                0: chk("idle_valid", 128'(cdb_valid), 128'd0);
                1: begin
                    if (exp_q.size() == 0) begin
                        chk("bcast_expected", 128'd0, 128'd1);
                    end else begin
                        e = exp_q.pop_front();
                        held = e;
                        chk("bcast", {cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc},
                            {1'b1, e.src, e.pos, e.val, e.jump, e.pc});
                    end
                end
                default: chk("freeze_hold", {cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc},
                             {1'b1, held.src, held.pos, held.val, held.jump, held.pc});
            endcase
        end
    end

    logic [RW-1:0] pos_ctr = 0;

    task automatic step(); @(negedge clk); endtask

    task automatic clear_valids();
        alu_valid = 0; lsb_valid = 0; mul_valid = 0;
    endtask

    task automatic set_alu(input logic [RW-1:0] p, input logic [31:0] v, input logic j, input logic [31:0] pc);
        alu_valid = 1; alu_rob_pos = p; alu_val = v; alu_jump = j; alu_pc = pc;
    endtask
    task automatic set_lsb(input logic [RW-1:0] p, input logic [31:0] v);
        lsb_valid = 1; lsb_rob_pos = p; lsb_val = v;
    endtask
    task automatic set_mul(input logic [RW-1:0] p, input logic [31:0] v);
        mul_valid = 1; mul_rob_pos = p; mul_val = v;
    endtask

    // Held-offer driver: an offer stays until accepted, then a new one may follow.
    task automatic run_random(input int cycles, input bit [2:0] mask, input int prob, input bit ctl);
        for (int c = 0; c < cycles; c++) begin
            if (!alu_valid || acc_alu) begin
                if (mask[0] && $urandom_range(99) < prob) begin
                    set_alu(pos_ctr, $urandom, 1'($urandom), $urandom); pos_ctr++;
                end else alu_valid = 0;
            end
            if (!lsb_valid || acc_lsb) begin
                if (mask[1] && $urandom_range(99) < prob) begin
                    set_lsb(pos_ctr, $urandom); pos_ctr++;
                end else lsb_valid = 0;
            end
            if (!mul_valid || acc_mul) begin
                if (mask[2] && $urandom_range(99) < prob) begin
                    set_mul(pos_ctr, $urandom); pos_ctr++;
                end else mul_valid = 0;
            end
            rdy      = ctl ? ($urandom_range(99) >= 10) : 1'b1;
            rollback = ctl ? ($urandom_range(99) < 3) : 1'b0;
            step();
        end
        rdy = 1; rollback = 0;
    endtask

    initial begin
        step(); step();
        rst = 0;
        step(); step();

        set_alu(5, 32'h1234, 1, 32'h80);
        step(); clear_valids();
        repeat (4) step();

        set_alu(1, 32'h11, 0, 32'h100); set_lsb(2, 32'h22); set_mul(3, 32'h33);
        step(); clear_valids();
        repeat (5) step();
        set_alu(4, 32'h44, 1, 32'h200); set_lsb(5, 32'h55); set_mul(6, 32'h66);
        step(); clear_valids();
        repeat (5) step();

        run_random(4, 3'b111, 100, 0);
        run_random(6, 3'b101, 100, 0);
        clear_valids();
        repeat (8) step();
        chk("lsb_backpressure_seen", 128'(seen_lsb_full), 128'd1);

        set_alu(8, 32'hA8, 0, 32'h300); set_mul(9, 32'hB9);
        step(); set_alu(10, 32'hAA, 1, 32'h304); mul_valid = 0;
        step(); set_alu(11, 32'hAB, 0, 32'h308);
        step(); clear_valids(); rollback = 1;
        step(); rollback = 0;
        set_alu(0, 32'hC0, 1, 32'h400);
        step(); clear_valids();
        repeat (4) step();

        set_alu(7, 32'h77, 1, 32'h500);
        step(); set_alu(12, 32'h78, 0, 32'h504);
        step(); clear_valids(); rdy = 0;
        repeat (3) step();
        rdy = 1;
        repeat (4) step();

        run_random(400, 3'b111, 60, 1);
        clear_valids();
        repeat (6) step();

        run_random(3, 3'b111, 100, 0);
        clear_valids(); rst = 1;
        step(); rst = 0;
        step();
        set_alu(1, 32'hD1, 1, 32'h600); set_lsb(2, 32'hD2); set_mul(3, 32'hD3);
        step(); clear_valids();
        repeat (6) step();

        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
